alu_exec: RTL

Execute stage of the RISC-V core. Consumes the 4-bit ALU operation code and register-write flag produced by the instruction control decoder, together with two 32-bit register operands and the destination register index. Produces a registered result, a zero flag and a write-back strobe for the register file. All operations except MUL complete in one cycle. MUL runs on an iterative 32-cycle shift-add engine, and the stage stalls upstream through a valid/ready handshake while it runs.

---
 rtl/alu_exec.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/alu_exec.sv
// Execute stage: single-cycle ALU ops plus a 32-step
// iterative shift-add multiplier behind a valid/ready stall.
module alu_exec #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_control,
  input  logic             regwrite_control,
  input  logic [4:0]       rd_in,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             wb_en,
  output logic [4:0]       wb_rd
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SLL = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0100;
  localparam logic [3:0] OP_SRL = 4'b0101;
  localparam logic [3:0] OP_MUL = 4'b0110;
  localparam logic [3:0] OP_XOR = 4'b0111;

  typedef enum logic {IDLE, MUL_RUN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    count_q, count_d;
  logic [4:0]       mul_rd_q, mul_rd_d;
  logic             mul_we_q, mul_we_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             zero_q, zero_d;
  logic [4:0]       rd_q, rd_d;
  logic             we_q, we_d;
  logic             ov_q, ov_d;

  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] acc_step;
  logic [CW-1:0]    shamt;

  assign shamt = op_b[CW-1:0];

  // Single-cycle result; undefined codes yield zero.
  always_comb begin
    alu_res = '0;
    case (alu_control)
      OP_AND:  alu_res = op_a & op_b;
      OP_OR:   alu_res = op_a | op_b;
      OP_ADD:  alu_res = op_a + op_b;
      OP_SLL:  alu_res = op_a << shamt;
      OP_SUB:  alu_res = op_a - op_b;
      OP_SRL:  alu_res = op_a >> shamt;
      OP_XOR:  alu_res = op_a ^ op_b;
      default: alu_res = '0;
    endcase
  end

  assign acc_step = mplier_q[0] ? acc_q + mcand_q : acc_q;

  // Next-state logic: accept in IDLE, iterate in MUL_RUN.
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    count_d  = count_q;
    mul_rd_d = mul_rd_q;
    mul_we_d = mul_we_q;
    res_d    = res_q;
    zero_d   = zero_q;
    rd_d     = rd_q;
    we_d     = we_q;
    ov_d     = 1'b0;
    in_ready = (state_q == IDLE);
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (alu_control == OP_MUL) begin
            mcand_d  = op_a;
            mplier_d = op_b;
            acc_d    = '0;
            count_d  = '0;
            mul_rd_d = rd_in;
            mul_we_d = regwrite_control;
            state_d  = MUL_RUN;
          end else begin
            res_d  = alu_res;
            zero_d = (alu_res == '0);
            rd_d   = rd_in;
            we_d   = regwrite_control;
            ov_d   = 1'b1;
          end
        end
      end
      MUL_RUN: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q + 1'b1;
        if (count_q == LAST) begin
          res_d   = acc_step;
          zero_d  = (acc_step == '0);
          rd_d    = mul_rd_q;
          we_d    = mul_we_q;
          ov_d    = 1'b1;
          count_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, multiplier datapath and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      count_q  <= '0;
      mul_rd_q <= '0;
      mul_we_q <= 1'b0;
      res_q    <= '0;
      zero_q   <= 1'b0;
      rd_q     <= '0;
      we_q     <= 1'b0;
      ov_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
      mul_rd_q <= mul_rd_d;
      mul_we_q <= mul_we_d;
      res_q    <= res_d;
      zero_q   <= zero_d;
      rd_q     <= rd_d;
      we_q     <= we_d;
      ov_q     <= ov_d;
    end
  end

  assign out_valid = ov_q;
  assign result    = res_q;
  assign zero      = zero_q;
  assign wb_rd     = rd_q;
  assign wb_en     = ov_q & we_q;

endmodule
